// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter: FSM states, requester ids and
// word-alignment test.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   typedef enum logic {OWN_CPU, OWN_LDR} owner_t;

   localparam int unsigned WORD_ALIGN_BITS = 2;

   function automatic logic is_aligned(input logic [WORD_ALIGN_BITS-1:0] lsbs);
      return lsbs == '0;
   endfunction

endpackage

// File: rtl/arb_burst_picker.sv
// Winner selection with a bounded burst: the current owner keeps winning ties until it has
// taken MAX_BURST consecutive grants.
module arb_burst_picker
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   cpu_req,
   input  logic   ldr_req,
   input  logic   grant,
   output owner_t winner
);

   localparam int unsigned CntW = $clog2(MAX_BURST + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   owner_t          owner_q, owner_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      winner = owner_q;
      if (cpu_req && ldr_req) begin
         if (cnt_q >= CntMax) begin
            winner = (owner_q == OWN_CPU) ? OWN_LDR : OWN_CPU;
         end
      end else if (cpu_req) begin
         winner = OWN_CPU;
      end else if (ldr_req) begin
         winner = OWN_LDR;
      end
   end

   always_comb begin
      owner_d = owner_q;
      cnt_d   = cnt_q;
      if (grant) begin
         if (winner == owner_q) begin
            if (cnt_q < CntMax) begin
               cnt_d = cnt_q + CntOne;
            end
         end else begin
            owner_d = winner;
            cnt_d   = CntOne;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q <= OWN_CPU;
         cnt_q   <= '0;
      end else begin
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the unified memory port: fixed IDLE->ACCESS->RESP
// transaction, ROM/RAM decode and misaligned-word rejection.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           MAX_BURST  = 4,
   parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = 32'h1001_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ack,
   output logic                  cpu_err,
   input  logic                  ldr_req,
   input  logic                  ldr_we,
   input  logic [ADDR_WIDTH-1:0] ldr_addr,
   input  logic [DATA_WIDTH-1:0] ldr_wdata,
   output logic                  ldr_ack,
   output logic                  ldr_err,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  mem_sel,
   input  logic [DATA_WIDTH-1:0] mem_q,
   output logic                  busy
);

   state_t                state_q, state_d;
   owner_t                who_q, who_d;
   owner_t                winner;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic                  grant;
   logic                  aligned;
   logic                  resp;

   assign grant   = (state_q == IDLE) && (cpu_req || ldr_req);
   assign aligned = is_aligned(addr_q[WORD_ALIGN_BITS-1:0]);
   assign resp    = (state_q == RESP);

   arb_burst_picker #(
      .MAX_BURST(MAX_BURST)
   ) u_picker (
      .clk    (clk),
      .reset  (reset),
      .cpu_req(cpu_req),
      .ldr_req(ldr_req),
      .grant  (grant),
      .winner (winner)
   );

   // Payload is captured only on the IDLE grant, so later requester changes are ignored.
   always_comb begin
      state_d = state_q;
      who_d   = who_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = ACCESS;
               who_d   = winner;
               if (winner == OWN_LDR) begin
                  addr_d  = ldr_addr;
                  wdata_d = ldr_wdata;
                  we_d    = ldr_we;
               end else begin
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
                  we_d    = cpu_we;
               end
            end
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         who_q   <= OWN_CPU;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         who_q   <= who_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   // Outputs decode straight from state so an asynchronous reset drops mem_we at once.
   always_comb begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_sel   = (addr_q >= RAM_BASE);
      mem_we    = (state_q == ACCESS) && we_q && aligned;
      busy      = (state_q != IDLE);
      cpu_ack   = resp && (who_q == OWN_CPU);
      ldr_ack   = resp && (who_q == OWN_LDR);
      cpu_err   = cpu_ack && !aligned;
      ldr_err   = ldr_ack && !aligned;
      rdata     = (resp && !we_q && aligned) ? mem_q : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset/burst corner sequences and
// randomized two-requester traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int          MaxBurst = 4;
   localparam logic [31:0] RamBase  = 32'h1001_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, ldr_req, ldr_we;
   logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
   logic        cpu_ack, cpu_err, ldr_ack, ldr_err;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_q;
   logic        mem_we, mem_sel, busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int          who;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pre;
      logic        exp_sel;
      logic        exp_err;
      logic        exp_we;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   mem_port_arbiter #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .MAX_BURST (MaxBurst),
      .RAM_BASE  (RamBase)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_ack  (cpu_ack),
      .cpu_err  (cpu_err),
      .ldr_req  (ldr_req),
      .ldr_we   (ldr_we),
      .ldr_addr (ldr_addr),
      .ldr_wdata(ldr_wdata),
      .ldr_ack  (ldr_ack),
      .ldr_err  (ldr_err),
      .rdata    (rdata),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we   (mem_we),
      .mem_sel  (mem_sel),
      .mem_q    (mem_q),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Word slot in a small memory image; ROM and RAM ranges used here never alias.
   function automatic int idx(input logic [31:0] a);
      return ((a >= RamBase) ? 64 : 0) + int'(a[7:2]);
   endfunction

   // Bench-side synchronous memory with one-cycle read latency.
   logic [31:0] dmem [128] = '{default: '0};
   logic        pre_en = 1'b0;
   logic [31:0] pre_addr = '0;
   logic [31:0] pre_data = '0;

   always @(posedge clk) begin
      if (pre_en) dmem[idx(pre_addr)] <= pre_data;
      else if (mem_we) dmem[idx(mem_addr)] <= mem_wdata;
      mem_q <= dmem[idx(mem_addr)];
   end

   // Reference model: one transaction per 3 cycles, arbitration from the owner/burst rules.
   logic [31:0] model_mem [128] = '{default: '0};
   int          m_phase, m_owner, m_cnt, m_win;
   logic [31:0] m_addr, m_wdata;
   logic        m_we;

   function automatic int pick(input logic c, input logic l, input int own, input int cnt);
      if (c && l) return (cnt < MaxBurst) ? own : 1 - own;
      return l ? 1 : 0;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase <= 0;
         m_owner <= 0;
         m_cnt   <= 0;
         m_win   <= 0;
      end else begin
         if (pre_en) model_mem[idx(pre_addr)] <= pre_data;
         if (m_phase == 0) begin
            if (cpu_req || ldr_req) begin
               m_win   <= pick(cpu_req, ldr_req, m_owner, m_cnt);
               m_addr  <= (pick(cpu_req, ldr_req, m_owner, m_cnt) == 1) ? ldr_addr : cpu_addr;
               m_wdata <= (pick(cpu_req, ldr_req, m_owner, m_cnt) == 1) ? ldr_wdata : cpu_wdata;
               m_we    <= (pick(cpu_req, ldr_req, m_owner, m_cnt) == 1) ? ldr_we : cpu_we;
               if (pick(cpu_req, ldr_req, m_owner, m_cnt) == m_owner) begin
                  m_cnt <= (m_cnt < MaxBurst) ? m_cnt + 1 : MaxBurst;
               end else begin
                  m_owner <= 1 - m_owner;
                  m_cnt   <= 1;
               end
               m_phase <= 1;
            end
         end else if (m_phase == 1) begin
            if (m_we && (m_addr[1:0] == 2'b00)) model_mem[idx(m_addr)] <= m_wdata;
            m_phase <= 2;
         end else begin
            m_phase <= 0;
         end
      end
   end

   int ack_who [$];
   int ack_cyc [$];

   always @(negedge clk) begin
      if (reset) begin
         if (cpu_ack) begin ack_who.push_back(0); ack_cyc.push_back(cyc); end
         if (ldr_ack) begin ack_who.push_back(1); ack_cyc.push_back(cyc); end
         if (m_phase == 0) begin
            chk("idle_busy", 32'(busy), 0);
            chk("idle_acks", 32'(cpu_ack | ldr_ack), 0);
            chk("idle_we", 32'(mem_we), 0);
         end else if (m_phase == 1) begin
            chk("acc_busy", 32'(busy), 1);
            chk("acc_addr", mem_addr, m_addr);
            chk("acc_sel", 32'(mem_sel), 32'(m_addr >= RamBase));
            chk("acc_we", 32'(mem_we), 32'(m_we && (m_addr[1:0] == 2'b00)));
            chk("acc_acks", 32'(cpu_ack | ldr_ack), 0);
            if (m_we) chk("acc_wdata", mem_wdata, m_wdata);
         end else begin
            chk("rsp_busy", 32'(busy), 1);
            chk("rsp_addr_held", mem_addr, m_addr);
            chk("rsp_we", 32'(mem_we), 0);
            chk("rsp_cpu_ack", 32'(cpu_ack), 32'(m_win == 0));
            chk("rsp_ldr_ack", 32'(ldr_ack), 32'(m_win == 1));
            chk("rsp_cpu_err", 32'(cpu_err), 32'((m_win == 0) && (m_addr[1:0] != 2'b00)));
            chk("rsp_ldr_err", 32'(ldr_err), 32'((m_win == 1) && (m_addr[1:0] != 2'b00)));
            chk("rsp_rdata", rdata,
                (!m_we && (m_addr[1:0] == 2'b00)) ? model_mem[idx(m_addr)] : 32'h0);
         end
      end
   end

   task automatic set_req(input int who, input logic r, input logic we, input logic [31:0] a,
                          input logic [31:0] d);
      if (who == 0) begin
         cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end else begin
         ldr_req = r; ldr_we = we; ldr_addr = a; ldr_wdata = d;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cpu_ack"}, 32'(cpu_ack), 0);
      chk({tag, "_ldr_ack"}, 32'(ldr_ack), 0);
      chk({tag, "_errs"}, 32'(cpu_err | ldr_err), 0);
      chk({tag, "_mem_we"}, 32'(mem_we), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_rdata"}, rdata, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_mem_sel"}, 32'(mem_sel), 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      @(posedge clk); @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      pre_addr = a; pre_data = d; pre_en = 1'b1;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   // Single isolated transaction; entered and left at posedge+1 of an IDLE cycle.
   task automatic run_one(input int n, input vec_t v);
      if (v.pre != 0) preload(v.addr, v.pre);
      set_req(v.who, 1, v.we, v.addr, v.wdata);
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d_addr", n), mem_addr, v.addr);
      chk($sformatf("v%0d_sel", n), 32'(mem_sel), 32'(v.exp_sel));
      chk($sformatf("v%0d_we", n), 32'(mem_we), 32'(v.exp_we));
      if (v.we) chk($sformatf("v%0d_wdata", n), mem_wdata, v.wdata);
      chk($sformatf("v%0d_early_ack", n), 32'(cpu_ack | ldr_ack), 0);
      @(negedge clk);
      chk($sformatf("v%0d_ack", n), 32'(v.who == 0 ? cpu_ack : ldr_ack), 1);
      chk($sformatf("v%0d_other_ack", n), 32'(v.who == 0 ? ldr_ack : cpu_ack), 0);
      chk($sformatf("v%0d_err", n), 32'(v.who == 0 ? cpu_err : ldr_err), 32'(v.exp_err));
      chk($sformatf("v%0d_rdata", n), rdata, v.exp_rdata);
      chk($sformatf("v%0d_we_rsp", n), 32'(mem_we), 0);
      @(posedge clk); #1;
      set_req(v.who, 0, 0, 0, 0);
   endtask

   // Requester that holds req/payload until its ack, then optionally idles a few cycles.
   task automatic run_req(input int who, input int n, input int max_gap);
      for (int i = 0; i < n; i++) begin
         int          gap;
         logic [31:0] a;
         logic        got;
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         if (gap > 0) begin
            set_req(who, 0, 0, 0, 0);
            repeat (gap) @(posedge clk);
            #1;
         end
         a = (($urandom_range(1, 0) == 1) ? RamBase : 32'h0040_0000) + ($urandom & 32'h3C);
         if ($urandom_range(3, 0) == 0) a = a + $urandom_range(3, 1);
         set_req(who, 1, $urandom_range(1, 0) == 1, a, $urandom);
         got = 1'b0;
         for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = (who == 0) ? cpu_ack : ldr_ack;
         end
         chk($sformatf("ack_wait_r%0d", who), 32'(got), 1);
         @(posedge clk); #1;
      end
      set_req(who, 0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int exp_order [8];
      vec_t abort_rd;

      vecs[0] = '{0, 1'b0, 32'h0040_0000, 32'h0, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h2008_0005};
      vecs[1] = '{1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0};
      vecs[2] = '{1, 1'b0, 32'h1001_0004, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[3] = '{0, 1'b1, 32'h0040_0002, 32'h5555_AAAA, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[4] = '{0, 1'b0, 32'h0040_0001, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[5] = '{0, 1'b0, 32'h1000_FFFC, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h1234_5678};
      vecs[6] = '{1, 1'b0, 32'h1001_0000, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D};
      vecs[7] = '{0, 1'b1, 32'h0040_0000, 32'h0BAD_C0DE, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0};
      vecs[8] = '{1, 1'b0, 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0BAD_C0DE};

      reset = 1'b0;
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check_reset_outputs("init");
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < 9; i++) run_one(i, vecs[i]);

      // Reset asserted in the middle of an ACCESS write.
      set_req(0, 1, 1, 32'h1001_0008, 32'h1111_2222);
      @(posedge clk); #2;
      chk("abort_we_before", 32'(mem_we), 1);
      reset = 1'b0;
      #1;
      check_reset_outputs("abort");
      set_req(0, 0, 0, 0, 0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_ack", 32'(cpu_ack | ldr_ack), 0);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      abort_rd = '{0, 1'b0, 32'h1001_0008, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
      run_one(99, abort_rd);

      // Both requesting continuously from a fresh reset.
      do_reset();
      ack_who.delete();
      ack_cyc.delete();
      fork
         run_req(0, 8, 0);
         run_req(1, 8, 0);
      join
      chk("burst_count", ack_who.size(), 16);
      if (ack_who.size() == 16) begin
         for (int i = 0; i < 16; i++) chk($sformatf("burst_who%0d", i), ack_who[i], (i / 4) % 2);
         for (int i = 1; i < 16; i++)
            chk($sformatf("burst_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
      end

      // Owner change on a lone request after a partial burst resets the count to 1.
      do_reset();
      ack_who.delete();
      run_req(0, 2, 0);
      run_req(1, 1, 0);
      fork
         run_req(0, 1, 0);
         run_req(1, 4, 0);
      join
      exp_order = '{0, 0, 1, 1, 1, 1, 0, 1};
      chk("switch_count", ack_who.size(), 8);
      if (ack_who.size() == 8) begin
         for (int i = 0; i < 8; i++) chk($sformatf("switch_who%0d", i), ack_who[i], exp_order[i]);
      end

      // Randomized traffic; the reference model checks every cycle.
      ack_who.delete();
      fork
         run_req(0, 40, 3);
         run_req(1, 40, 3);
      join
      chk("rand_acks", ack_who.size(), 80);
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port unified Memory Unit of the multicycle MIPS core. It sits between the MIPS datapath's memory address/data path (requester 0, "cpu") and a boot/debug loader (requester 1, "ldr"). It serialises their accesses over one memory port, decodes ROM/RAM selection from the address, and rejects misaligned word accesses. Each granted access is a fixed three-state transaction with a one-cycle acknowledge.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte-address width
- MAX_BURST, 4, consecutive grants the current owner may keep while the other requester waits (≥1)
- RAM_BASE, 32'h1001_0000, first RAM byte address; lower addresses select ROM

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_req / ldr_req  in  1  access request; held with payload until ack
- cpu_we / ldr_we  in  1  1=write, 0=read
- cpu_addr / ldr_addr  in  ADDR_WIDTH  byte address
- cpu_wdata / ldr_wdata  in  DATA_WIDTH  write data
- cpu_ack / ldr_ack  out  1  one-cycle completion pulse
- cpu_err / ldr_err  out  1  valid with ack; 1 = misaligned, no access performed
- rdata  out  DATA_WIDTH  read data, valid in the ack cycle
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_we  out  1  memory write enable
- mem_sel  out  1  0=ROM, 1=RAM
- mem_q  in  DATA_WIDTH  memory read data, synchronous, one-cycle latency
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE → ACCESS → RESP → IDLE, with no other transitions. RESP always returns to IDLE, so requesters see ack before the next sample.
- IDLE: if no request, stay. Otherwise pick a winner, register its addr, we, and wdata, and go to ACCESS.
- Winner selection:
  - Only one requester active: that requester wins.
  - Both active: the owner wins if burst_cnt < MAX_BURST; otherwise the other requester wins.
  - Owner and burst_cnt after reset: owner = cpu, burst_cnt = 0.
- Burst counter:
  - Grant to the current owner: burst_cnt increments, saturating at MAX_BURST.
  - Grant to the other requester: owner switches and burst_cnt = 1.
- ACCESS:
  - mem_addr, mem_wdata, and mem_sel = (addr ≥ RAM_BASE) are driven from the registered payload.
  - mem_we = registered we AND aligned, where aligned = (addr[1:0] == 0).
- RESP:
  - The winner's ack = 1 and err = !aligned.
  - rdata = mem_q for an aligned read; rdata = 0 for a write or a misaligned access.
- mem_addr, mem_wdata, and mem_sel are held in RESP and IDLE; they are don't-care outside ACCESS but must be stable.
- A misaligned access still occupies the full three cycles and counts as a grant.

## Timing
- Reset values of all outputs: ack, err, mem_we, and busy = 0; rdata, mem_addr, mem_wdata, and mem_sel = 0.
- Reset also sets state = IDLE, owner = cpu, burst_cnt = 0.
- Reset is asynchronous. Asserting it mid-transaction drops mem_we immediately, and no ack is issued for the aborted access.
- Latency: req sampled high at edge ending cycle n (IDLE) → ACCESS in n+1 → ack in n+2.
  - Write data is committed at the edge ending n+1.
- Throughput: one access per 3 cycles, with no idle gap for back-to-back requests.
- Handshake:
  - A requester keeps req and payload stable from assertion until its ack.
  - It may deassert req or present new payload in the cycle after ack.
  - Payload changes before ack are ignored, because the payload is latched in IDLE.
- Simultaneous first requests after reset: cpu wins.

## Structure
- Package mem_arb_pkg holds:
  - typedef state_t {IDLE, ACCESS, RESP}
  - typedef owner_t {OWN_CPU, OWN_LDR}
  - localparam WORD_ALIGN_BITS = 2
- Sub-module arb_burst_picker contains the owner register, burst_cnt, and the winner logic. Inputs: two reqs and the IDLE-grant strobe. Output: winner.
- The top level contains the FSM, payload registers, address decode, and response muxing.

## Test plan
- Reset with reset=0 mid-ACCESS on a write → mem_we=0 immediately, all outputs 0, no ack; after release, the first tie goes to cpu.
- cpu read 0x0040_0000, mem_q=0x2008_0005 → mem_addr=0x0040_0000 and mem_sel=0 in n+1; cpu_ack=1, cpu_err=0, rdata=0x2008_0005 in n+2.
- ldr write 0x1001_0004 with 0xDEAD_BEEF → mem_we=1 for exactly one cycle, mem_sel=1, mem_wdata=0xDEAD_BEEF; ldr_ack in n+2, rdata=0.
- Both requesting continuously, MAX_BURST=4 → grant order cpu×4, ldr×4, cpu×4; no acks overlap; 3 cycles per access.
- cpu write to 0x0040_0002 → mem_we stays 0, cpu_ack=1 with cpu_err=1, and the access counts toward burst_cnt.
- cpu owner at burst_cnt=2 with ldr idle, then ldr requests alone → ldr granted next IDLE, owner switches, burst_cnt=1.
